// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction-fetch front end of the multi-cycle
// CPU.
//   - pc_src_e      : next-PC select encodings driven by the control unit
//   - fetch_state_e : states of the instruction-fetch handshake FSM
//   - RESET_PC_DEFAULT : default PC loaded on reset
//   - IR_* localparams : bit positions of the MIPS-style instruction fields
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,  // pc + 4
    PC_BR  = 2'b01,  // pc + 4 + (imm << 2)
    PC_JR  = 2'b10,  // register target
    PC_J   = 2'b11   // pseudo-direct jump
  } pc_src_e;

  typedef enum logic [1:0] {
    F_IDLE = 2'b00,
    F_WAIT = 2'b01,
    F_DONE = 2'b10
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction field positions
  localparam int IR_OP_HI   = 31;
  localparam int IR_OP_LO   = 26;
  localparam int IR_RS_HI   = 25;
  localparam int IR_RS_LO   = 21;
  localparam int IR_RT_HI   = 20;
  localparam int IR_RT_LO   = 16;
  localparam int IR_RD_HI   = 15;
  localparam int IR_RD_LO   = 11;
  localparam int IR_SA_HI   = 10;
  localparam int IR_SA_LO   = 6;
  localparam int IR_IMM_HI  = 15;
  localparam int IR_IMM_LO  = 0;
  localparam int IR_JIDX_HI = 25;
  localparam int IR_JIDX_LO = 0;

endpackage : cpu_pkg

// File: rtl/next_pc_calc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
// Purely combinational next-PC computation: sequential, branch, register and
// pseudo-direct jump targets, plus the pc+4 value used for link write-back.
// All arithmetic wraps modulo 2^AW.
// Ports:
//   pc        in  AW  current PC
//   pc_src    in  2   target select (pc_src_e encoding)
//   ext_imm   in  32  extended branch immediate (word offset)
//   jr_target in  32  register value for jr
//   jidx      in  26  jump index from IR[25:0]
//   pc_plus4  out AW  pc + 4
//   next_pc   out AW  selected next PC
// -----------------------------------------------------------------------------
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] pc,
  input  logic [1:0]    pc_src,
  input  logic [31:0]   ext_imm,
  input  logic [31:0]   jr_target,
  input  logic [25:0]   jidx,
  output logic [AW-1:0] pc_plus4,
  output logic [AW-1:0] next_pc
);

  logic [AW-1:0] br_target;
  logic [AW-1:0] j_target;

  assign pc_plus4  = pc + AW'(4);
  assign br_target = pc_plus4 + AW'(ext_imm << 2);
  // Jump keeps the upper bits of the sequential PC and replaces the rest
  // with the word-aligned jump index.
  assign j_target  = {pc_plus4[AW-1:28], jidx, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PC_SEQ:  next_pc = pc_plus4;
      PC_BR:   next_pc = br_target;
      PC_JR:   next_pc = AW'(jr_target);
      PC_J:    next_pc = j_target;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule : next_pc_calc

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Holds the PC, updates it from the control unit's PCSrc/PCWre, fetches the
// instruction word over a request/valid handshake into the instruction
// register and presents the decoded fields.
// Optional feature (macro PC_ALIGN_CHK_EN): a PC write whose target is not
// word aligned is suppressed and raises a sticky misalign_err output.
// Ports:
//   CLK, RST            clock; synchronous active-low reset
//   PCWre, PCSrc        PC write enable and next-PC select
//   IRWre               fetch start request
//   ext_imm, jr_target  branch immediate, jr register value
//   imem_addr/req       fetch address and request (held until valid)
//   imem_rdata/valid    returned instruction word and its strobe
//   pc, pc_plus4        current PC and PC+4
//   opCode..imm16       fields of the instruction register
//   ir_valid            IR holds the word of the latest request
//   fetch_busy          request outstanding
//   misalign_err        (PC_ALIGN_CHK_EN only) sticky misaligned-target flag
// -----------------------------------------------------------------------------
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          AW       = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PCWre,
  input  logic [1:0]    PCSrc,
  input  logic          IRWre,
  input  logic [31:0]   ext_imm,
  input  logic [31:0]   jr_target,
  output logic [AW-1:0] imem_addr,
  output logic          imem_req,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_valid,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_plus4,
  output logic [5:0]    opCode,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic [4:0]    sa,
  output logic [15:0]   imm16,
  output logic          ir_valid,
  output logic          fetch_busy
`ifdef PC_ALIGN_CHK_EN
  ,
  output logic          misalign_err
`endif
);

  logic [31:0]   ir;
  logic [AW-1:0] next_pc;
  logic          pc_load;

  fetch_state_e state, state_nxt;
  logic         addr_capture;
  logic         ir_load;

  next_pc_calc #(.AW(AW)) u_next_pc (
    .pc        (pc),
    .pc_src    (PCSrc),
    .ext_imm   (ext_imm),
    .jr_target (jr_target),
    .jidx      (ir[IR_JIDX_HI:IR_JIDX_LO]),
    .pc_plus4  (pc_plus4),
    .next_pc   (next_pc)
  );

`ifdef PC_ALIGN_CHK_EN
  logic misaligned;
  assign misaligned = (next_pc[1:0] != 2'b00);
  assign pc_load    = PCWre && !misaligned;
`else
  assign pc_load    = PCWre;
`endif

  // Fetch FSM next-state logic. IRWre is only honoured outside F_WAIT, so a
  // request is never duplicated while one is outstanding.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a value unassigned and infers a latch.
    state_nxt    = state;
    addr_capture = 1'b0;
    ir_load      = 1'b0;
    case (state)
      F_IDLE, F_DONE: begin
        if (IRWre) begin
          state_nxt    = F_WAIT;
          addr_capture = 1'b1;
        end
      end
      F_WAIT: begin
        if (imem_valid) begin
          state_nxt = F_DONE;
          ir_load   = 1'b1;
        end
      end
      default: state_nxt = F_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, e.g. the fetch captures the old pc even when
    // PCWre lands on the same edge.
    if (!RST) begin
      pc        <= AW'(RESET_PC);
      ir        <= 32'h0000_0000;
      imem_addr <= AW'(RESET_PC);
      state     <= F_IDLE;
    end else begin
      state <= state_nxt;
      if (pc_load)      pc        <= next_pc;
      if (addr_capture) imem_addr <= pc;
      if (ir_load)      ir        <= imem_rdata;
    end
  end

`ifdef PC_ALIGN_CHK_EN
  always_ff @(posedge CLK) begin
    if (!RST)                        misalign_err <= 1'b0;
    else if (PCWre && misaligned)    misalign_err <= 1'b1;
  end
`endif

  assign imem_req   = (state == F_WAIT);
  assign fetch_busy = (state == F_WAIT);
  assign ir_valid   = (state == F_DONE);

  assign opCode = ir[IR_OP_HI:IR_OP_LO];
  assign rs     = ir[IR_RS_HI:IR_RS_LO];
  assign rt     = ir[IR_RT_HI:IR_RT_LO];
  assign rd     = ir[IR_RD_HI:IR_RD_LO];
  assign sa     = ir[IR_SA_HI:IR_SA_LO];
  assign imm16  = ir[IR_IMM_HI:IR_IMM_LO];

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Directed scenarios followed by a randomized run against a behavioural model
// of the PC/fetch unit. Define PC_ALIGN_CHK_EN for both bench and RTL to cover
// the alignment check.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic        IRWre;
  logic [31:0] ext_imm;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [5:0]  opCode;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm16;
  logic        ir_valid;
  logic        fetch_busy;
`ifdef PC_ALIGN_CHK_EN
  logic        misalign_err;
`endif

  int vectors     = 0;
  int miscompares = 0;

  pc_fetch_unit dut (
    .CLK        (CLK),
    .RST        (RST),
    .PCWre      (PCWre),
    .PCSrc      (PCSrc),
    .IRWre      (IRWre),
    .ext_imm    (ext_imm),
    .jr_target  (jr_target),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .opCode     (opCode),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .sa         (sa),
    .imm16      (imm16),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy)
`ifdef PC_ALIGN_CHK_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  always #5 CLK = ~CLK;

  // One clock edge; outputs are observed 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    PCWre      = 1'b0;
    PCSrc      = 2'b00;
    IRWre      = 1'b0;
    ext_imm    = 32'h0;
    jr_target  = 32'h0;
    imem_rdata = 32'h0;
    imem_valid = 1'b0;
  endtask

  // Behavioural next-PC: plain arithmetic on the architectural rules.
  function automatic logic [31:0] model_next_pc(input logic [31:0] cur_pc,
                                                input logic [1:0]  src,
                                                input logic [31:0] imm,
                                                input logic [31:0] jr,
                                                input logic [31:0] instr);
    logic [31:0] seq;
    seq = cur_pc + 32'd4;
    case (src)
      2'd1:    return seq + imm * 32'd4;
      2'd2:    return jr;
      2'd3:    return (seq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 32'd4);
      default: return seq;
    endcase
  endfunction

  task automatic test_reset();
    idle_inputs();
    RST = 1'b0;
    tick();
    tick();
    vectors++;
    if (pc !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_pc: got %h want %h", pc, 32'h0);
    end
    vectors++;
    if ({imem_req, fetch_busy, ir_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got req/busy/valid=%b want 000", {imem_req, fetch_busy, ir_valid});
    end
    vectors++;
    if ({opCode, rs, rt, imm16} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_ir: got %h want 0", {opCode, rs, rt, imm16});
    end
    vectors++;
    if (pc_plus4 !== 32'h4) begin
      miscompares++;
      $display("FAIL reset_pc_plus4: got %h want %h", pc_plus4, 32'h4);
    end
  endtask

  task automatic test_first_fetch();
    RST   = 1'b1;
    IRWre = 1'b1;
    tick();
    IRWre = 1'b0;
    vectors++;
    if ({imem_req, fetch_busy, ir_valid} !== 3'b110 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL fetch_request: got req/busy/valid=%b addr=%h want 110 addr=0",
               {imem_req, fetch_busy, ir_valid}, imem_addr);
    end
    imem_valid = 1'b1;
    imem_rdata = 32'h0022_0800;
    tick();
    imem_valid = 1'b0;
    vectors++;
    if ({opCode, rs, rt, rd} !== {6'd0, 5'd1, 5'd2, 5'd1}) begin
      miscompares++;
      $display("FAIL fetch_fields: got op=%0d rs=%0d rt=%0d rd=%0d want 0 1 2 1", opCode, rs, rt, rd);
    end
    vectors++;
    if ({imem_req, fetch_busy, ir_valid} !== 3'b001) begin
      miscompares++;
      $display("FAIL fetch_done: got req/busy/valid=%b want 001", {imem_req, fetch_busy, ir_valid});
    end
  endtask

  task automatic test_branch();
    // Walk pc from 0 to 0x10 sequentially, then branch by -2 words.
    PCSrc = 2'b00;
    PCWre = 1'b1;
    repeat (4) tick();
    vectors++;
    if (pc !== 32'h10) begin
      miscompares++;
      $display("FAIL seq_pc: got %h want %h", pc, 32'h10);
    end
    PCSrc   = 2'b01;
    ext_imm = 32'hFFFF_FFFE;
    tick();
    PCWre = 1'b0;
    vectors++;
    if (pc !== 32'h0C) begin
      miscompares++;
      $display("FAIL branch_pc: got %h want %h", pc, 32'h0C);
    end
    tick();
    vectors++;
    if (pc !== 32'h0C) begin
      miscompares++;
      $display("FAIL hold_pc: got %h want %h", pc, 32'h0C);
    end
  endtask

  task automatic test_jump();
    // Load a jump instruction with index 0x10 into the IR.
    IRWre = 1'b1;
    tick();
    IRWre      = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'h0800_0010;
    tick();
    imem_valid = 1'b0;
    PCSrc = 2'b11;
    PCWre = 1'b1;
    tick();
    vectors++;
    if (pc !== 32'h40) begin
      miscompares++;
      $display("FAIL jump_pc: got %h want %h", pc, 32'h40);
    end
    PCSrc     = 2'b10;
    jr_target = 32'h80;
    tick();
    PCWre = 1'b0;
    vectors++;
    if (pc !== 32'h80) begin
      miscompares++;
      $display("FAIL jr_pc: got %h want %h", pc, 32'h80);
    end
  endtask

  task automatic test_wait_overlap();
    logic [31:0] word;
    word  = $urandom;
    IRWre = 1'b1;
    tick();
    // Second IRWre plus a PC write while the request is outstanding.
    PCSrc = 2'b00;
    PCWre = 1'b1;
    tick();
    PCWre = 1'b0;
    IRWre = 1'b0;
    tick();
    vectors++;
    if (imem_addr !== 32'h80 || imem_req !== 1'b1 || pc !== 32'h84) begin
      miscompares++;
      $display("FAIL wait_hold: got addr=%h req=%b pc=%h want addr=80 req=1 pc=84",
               imem_addr, imem_req, pc);
    end
    imem_valid = 1'b1;
    imem_rdata = word;
    tick();
    imem_valid = 1'b0;
    vectors++;
    if ({opCode, rs, rt, rd, sa} !== word[31:6] || imm16 !== word[15:0] || ir_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_ir: got %h%h valid=%b want %h valid=1",
               {opCode, rs, rt, rd, sa}, imm16[5:0], ir_valid, word);
    end
    tick();
    vectors++;
    if (imem_req !== 1'b0 || fetch_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_request: got req=%b busy=%b want 0 0", imem_req, fetch_busy);
    end
    // Same-edge IRWre and PCWre: fetch uses the old pc.
    IRWre = 1'b1;
    PCWre = 1'b1;
    tick();
    IRWre = 1'b0;
    PCWre = 1'b0;
    vectors++;
    if (imem_addr !== 32'h84 || pc !== 32'h88 || ir_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL same_edge: got addr=%h pc=%h valid=%b want 84 88 0", imem_addr, pc, ir_valid);
    end
  endtask

  task automatic test_reset_mid_fetch();
    // The same-edge test leaves a request outstanding.
    RST = 1'b0;
    tick();
    RST        = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    tick();
    imem_valid = 1'b0;
    vectors++;
    if ({opCode, rs, rt, imm16} !== 32'h0 || ir_valid !== 1'b0 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abandon: got ir=%h valid=%b req=%b want 0 0 0",
               {opCode, rs, rt, imm16}, ir_valid, imem_req);
    end
    vectors++;
    if (pc !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_abandon_pc: got %h want %h", pc, 32'h0);
    end
  endtask

`ifdef PC_ALIGN_CHK_EN
  task automatic test_misalign();
    RST = 1'b0;
    tick();
    RST       = 1'b1;
    PCSrc     = 2'b10;
    jr_target = 32'h82;
    PCWre     = 1'b1;
    tick();
    vectors++;
    if (pc !== 32'h0 || misalign_err !== 1'b1) begin
      miscompares++;
      $display("FAIL misalign_set: got pc=%h err=%b want 0 1", pc, misalign_err);
    end
    PCSrc = 2'b00;
    tick();
    PCWre = 1'b0;
    vectors++;
    if (pc !== 32'h4 || misalign_err !== 1'b1) begin
      miscompares++;
      $display("FAIL misalign_sticky: got pc=%h err=%b want 4 1", pc, misalign_err);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] m_pc, m_ir, m_addr, n_pc;
    logic        m_busy, m_valid, m_err;
    RST = 1'b0;
    idle_inputs();
    tick();
    m_pc = 32'h0; m_ir = 32'h0; m_addr = 32'h0;
    m_busy = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 500; i++) begin
      RST        = ($urandom_range(0, 59) != 0);
      PCWre      = $urandom_range(0, 1);
      PCSrc      = $urandom_range(0, 3);
      IRWre      = ($urandom_range(0, 2) == 0);
      ext_imm    = $urandom;
      jr_target  = $urandom;
      if ($urandom_range(0, 7) != 0) jr_target[1:0] = 2'b00;
      imem_valid = ($urandom_range(0, 2) == 0);
      imem_rdata = $urandom;
      #1;
      // Model update from pre-edge state and inputs.
      if (!RST) begin
        m_pc = 32'h0; m_ir = 32'h0; m_busy = 1'b0; m_valid = 1'b0; m_err = 1'b0;
      end else begin
        n_pc = model_next_pc(m_pc, PCSrc, ext_imm, jr_target, m_ir);
        if (m_busy) begin
          if (imem_valid) begin
            m_ir = imem_rdata; m_busy = 1'b0; m_valid = 1'b1;
          end
        end else if (IRWre) begin
          m_addr = m_pc; m_busy = 1'b1; m_valid = 1'b0;
        end
`ifdef PC_ALIGN_CHK_EN
        if (PCWre && n_pc[1:0] != 2'b00) m_err = 1'b1;
        else if (PCWre) m_pc = n_pc;
`else
        if (PCWre) m_pc = n_pc;
`endif
      end
      tick();
      vectors++;
      if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4) begin
        miscompares++;
        $display("FAIL rand_pc[%0d]: got pc=%h p4=%h want %h", i, pc, pc_plus4, m_pc);
      end
      vectors++;
      if ({imem_req, fetch_busy, ir_valid} !== {m_busy, m_busy, m_valid}) begin
        miscompares++;
        $display("FAIL rand_flags[%0d]: got req/busy/valid=%b want %b", i,
                 {imem_req, fetch_busy, ir_valid}, {m_busy, m_busy, m_valid});
      end
      vectors++;
      if ({opCode, rs, rt, rd, sa} !== m_ir[31:6] || imm16 !== m_ir[15:0]) begin
        miscompares++;
        $display("FAIL rand_ir[%0d]: got %h/%h want %h", i, {opCode, rs, rt, rd, sa}, imm16, m_ir);
      end
      if (m_busy) begin
        vectors++;
        if (imem_addr !== m_addr) begin
          miscompares++;
          $display("FAIL rand_addr[%0d]: got %h want %h", i, imem_addr, m_addr);
        end
      end
`ifdef PC_ALIGN_CHK_EN
      vectors++;
      if (misalign_err !== m_err) begin
        miscompares++;
        $display("FAIL rand_misalign[%0d]: got %b want %b", i, misalign_err, m_err);
      end
`endif
    end
  endtask

  initial begin
    RST = 1'b0;
    idle_inputs();
    test_reset();
    test_first_fetch();
    test_branch();
    test_jump();
    test_wait_overlap();
    test_reset_mid_fetch();
`ifdef PC_ALIGN_CHK_EN
    test_misalign();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pc_fetch_unit

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Upstream neighbour of the multi-cycle control unit.
- Holds the PC and computes the next PC from PCSrc/PCWre.
- Fetches the instruction word from instruction memory over a valid handshake and holds it in the instruction register.
- Presents opCode and the decoded fields to the control unit and datapath.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- AW, 32, PC/address width.

Ports:
- CLK  in  1  clock, all state updates on posedge.
- RST  in  1  synchronous active-low reset.
- PCWre  in  1  PC write enable from control unit.
- PCSrc  in  2  next-PC select: 00 pc+4, 01 branch, 10 jr, 11 jump.
- IRWre  in  1  fetch start / IR write request from control unit.
- ext_imm  in  32  sign/zero-extended immediate.
- jr_target  in  32  register value for jr.
- imem_addr  out  AW  fetch address.
- imem_req  out  1  fetch request, held until accepted.
- imem_rdata  in  32  instruction word.
- imem_valid  in  1  rdata valid; completes the request.
- pc  out  AW  current PC.
- pc_plus4  out  AW  pc+4, used for jal write-back.
- opCode  out  6  IR[31:26].
- rs, rt, rd  out  5 each  IR[25:21], IR[20:16], IR[15:11].
- sa  out  5  IR[10:6].
- imm16  out  16  IR[15:0].
- ir_valid  out  1  IR holds the word fetched at the current request.
- fetch_busy  out  1  request outstanding.

Behaviour:
- Reset (RST==0 at posedge): pc=RESET_PC, IR=32'h0000_0000, ir_valid=0, imem_req=0, fetch_busy=0, state=F_IDLE. Reset mid-fetch abandons the request; a late imem_valid after reset is ignored.
- Next PC, combinational, 32-bit, wrap-around permitted:
  - 00: pc+4.
  - 01: pc+4+(ext_imm<<2).
  - 10: jr_target.
  - 11: {pc_plus4[31:28], IR[25:0], 2'b00}.
  - Any other value: pc+4.
- pc is updated on the posedge when PCWre==1, with no added latency. pc_plus4 = pc+4, combinational.
- Fetch FSM:
  - F_IDLE: IRWre==1 → capture imem_addr=pc, imem_req=1, ir_valid=0, go to F_WAIT.
  - F_WAIT: imem_req held and imem_addr stable. imem_valid==1 → IR<=imem_rdata, imem_req=0, ir_valid=1, go to F_DONE.
  - F_DONE: hold IR, ir_valid=1. IRWre==1 → new request as in F_IDLE.
- Latency: the IR updates on the same edge that samples imem_valid. If imem_valid is high in the first request cycle, the fetch takes 1 cycle.
- IRWre during F_WAIT is ignored; there is no second request.
- PCWre during F_WAIT updates pc, but imem_addr keeps the captured address.
- PCWre and IRWre on the same edge: the fetch uses the old pc; the PC update lands.
- fetch_busy = (state==F_WAIT).
- Decoded fields always reflect the IR, even when ir_valid==0.

Optional Feature:
- Macro: PC_ALIGN_CHK_EN.
- When defined:
  - Adds output misalign_err (1 bit), reset 0.
  - If PCWre==1 and next_pc[1:0]!=0, pc is NOT updated and misalign_err is set.
  - misalign_err is sticky until reset.
- When undefined:
  - No misalign_err port.
  - The PC always takes next_pc unchanged.

Decomposition:
- Shared package cpu_pkg holds:
  - PCSrc encodings (PC_SEQ, PC_BR, PC_JR, PC_J).
  - Fetch state enum (F_IDLE, F_WAIT, F_DONE).
  - RESET_PC default.
  - IR field bit positions.
- One natural sub-module: next_pc_calc, combinational, covering the four-way target mux and adders. The FSM and registers stay in the top level.

Test Plan:
- Reset then IRWre=1, imem_valid high the next cycle with rdata=32'h0022_0800 → imem_addr=0, opCode=000000, rs=1, rt=2, rd=1, ir_valid=1 after 1 cycle.
- pc=0x10, PCSrc=01, ext_imm=0xFFFF_FFFE, PCWre=1 → pc=0x0C.
- IR[25:0]=26'h000_0010, pc=0x40, PCSrc=11, PCWre → pc=0x40. PCSrc=10 with jr_target=0x80 → pc=0x80.
- IRWre, imem_valid delayed 3 cycles, with a second IRWre and a PCWre during the wait → single request, imem_addr unchanged, IR latched on the valid edge, pc updated.
- RST=0 asserted in F_WAIT, then imem_valid=1 → IR stays 0, ir_valid=0, pc=RESET_PC.
- With PC_ALIGN_CHK_EN: PCSrc=10, jr_target=0x82, PCWre → pc unchanged, misalign_err=1 and still 1 after later PCWre to an aligned target.
